// File: rtl/bg_scroll_pkg.sv
// Shared constants and types for the background scroll generator:
// register offsets, CPU write FSM states and default path widths.
package bg_scroll_pkg;

  localparam int unsigned SCRL_H_WIDTH = 9;
  localparam int unsigned SCRL_V_WIDTH = 8;

  // Register offsets relative to SCRL_BASE; offset 3 is unmapped
  localparam logic [1:0] SCRL_XLO = 2'd0;
  localparam logic [1:0] SCRL_XHI = 2'd1;
  localparam logic [1:0] SCRL_Y   = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    HOLD    = 2'd2
  } wr_state_t;

endpackage

// File: rtl/bg_scroll_gen_if.sv
// CPU write port of the scroll register block (active-low strobes).
interface bg_scroll_gen_if;

  logic       SCROLL_CS;
  logic       Z80_WR;
  logic [1:0] CPU_ADDR;
  logic [7:0] CPU_DIN;

  modport master (output SCROLL_CS, output Z80_WR, output CPU_ADDR, output CPU_DIN);
  modport slave  (input  SCROLL_CS, input  Z80_WR, input  CPU_ADDR, input  CPU_DIN);

endinterface

// File: rtl/bg_scroll_gen_edge_detect.sv
// Rising-edge pulse generator: rise is high for the one cycle where din
// is high and was low on the previous clock.
module bg_scroll_gen_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic din_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) din_q <= 1'b0;
    else        din_q <= din;
  end

  assign rise = din & ~din_q;

endmodule

// File: rtl/bg_scroll_gen.sv
// Background scroll generator: CPU shadow scroll registers, blank-synchronous
// active copies and registered scrolled beam position. Optional per-line X
// reload at HBLANK is enabled by defining BG_LINE_SCROLL_EN.
module bg_scroll_gen
  import bg_scroll_pkg::*;
#(
  parameter logic [1:0]  SCRL_BASE = 2'b00,
  parameter int unsigned H_WIDTH   = SCRL_H_WIDTH,
  parameter int unsigned V_WIDTH   = SCRL_V_WIDTH
) (
  input  logic               master_clk,
  input  logic               reset_n,
  input  logic               pixel_ce,
  input  logic [H_WIDTH-1:0] HPIX,
  input  logic [V_WIDTH-1:0] VPIX,
  input  logic               HBLANK,
  input  logic               VBLANK,
  input  logic               SCREEN_FLIP,
  bg_scroll_gen_if.slave     cpu,
  output logic [H_WIDTH-1:0] HPIXSCRL,
  output logic [V_WIDTH-1:0] VPIXSCRL,
  output logic               scroll_dirty
);

  wr_state_t          state, state_nxt;
  logic               capture;
  logic               strobe;
  logic [1:0]         reg_sel;
  logic [H_WIDTH-1:0] shadow_x, active_x;
  logic [V_WIDTH-1:0] shadow_y, active_y;
  logic               v_rise;
  logic               x_load;

  assign strobe  = !cpu.SCROLL_CS && !cpu.Z80_WR;
  assign reg_sel = cpu.CPU_ADDR - SCRL_BASE;

  always_ff @(posedge master_clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // HOLD waits for strobe release so a long strobe produces a single write
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE:    if (strobe) state_nxt = CAPTURE;
      CAPTURE: begin
        capture   = 1'b1;
        state_nxt = HOLD;
      end
      HOLD:    if (!strobe) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge master_clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_x <= '0;
      shadow_y <= '0;
    end else if (capture) begin
      case (reg_sel)
        SCRL_XLO: shadow_x[7:0]         <= cpu.CPU_DIN;
        SCRL_XHI: shadow_x[H_WIDTH-1:8] <= cpu.CPU_DIN[H_WIDTH-9:0];
        SCRL_Y:   shadow_y              <= cpu.CPU_DIN[V_WIDTH-1:0];
        default:  ;
      endcase
    end
  end

  bg_scroll_gen_edge_detect u_vblank_edge (
    .clk   (master_clk),
    .rst_n (reset_n),
    .din   (VBLANK),
    .rise  (v_rise)
  );

`ifdef BG_LINE_SCROLL_EN
  logic h_rise;

  bg_scroll_gen_edge_detect u_hblank_edge (
    .clk   (master_clk),
    .rst_n (reset_n),
    .din   (HBLANK),
    .rise  (h_rise)
  );

  assign x_load = v_rise | h_rise;
`else
  logic unused_hblank;

  assign unused_hblank = HBLANK;
  assign x_load        = v_rise;
`endif

  // Active copies sample the pre-write shadow when a capture lands on a load edge
  always_ff @(posedge master_clk or negedge reset_n) begin
    if (!reset_n) begin
      active_x <= '0;
      active_y <= '0;
    end else begin
      if (x_load) active_x <= shadow_x;
      if (v_rise) active_y <= shadow_y;
    end
  end

  // Dirty clears only at VBLANK, where both axes reload; a coincident write keeps it set
  always_ff @(posedge master_clk or negedge reset_n) begin
    if (!reset_n)     scroll_dirty <= 1'b0;
    else if (capture) scroll_dirty <= 1'b1;
    else if (v_rise)  scroll_dirty <= 1'b0;
  end

  always_ff @(posedge master_clk or negedge reset_n) begin
    if (!reset_n) begin
      HPIXSCRL <= '0;
      VPIXSCRL <= '0;
    end else if (pixel_ce) begin
      HPIXSCRL <= (SCREEN_FLIP ? ~HPIX : HPIX) + active_x;
      VPIXSCRL <= (SCREEN_FLIP ? ~VPIX : VPIX) + active_y;
    end
  end

endmodule

// File: tb/tb_bg_scroll_gen.sv
// Directed and randomized bench for bg_scroll_gen, checked against an
// arithmetic model of the shadow/active scroll registers.
module tb_bg_scroll_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pixel_ce = 1'b0;
  logic       hblank = 1'b0;
  logic       vblank = 1'b0;
  logic       flip = 1'b0;
  logic [8:0] hpix = '0;
  logic [7:0] vpix = '0;
  logic [8:0] hscrl;
  logic [7:0] vscrl;
  logic       dirty;

  bg_scroll_gen_if cpu ();

  always #5 clk = ~clk;

  bg_scroll_gen #(.SCRL_BASE(2'b00), .H_WIDTH(9), .V_WIDTH(8)) dut (
    .master_clk   (clk),
    .reset_n      (rst_n),
    .pixel_ce     (pixel_ce),
    .HPIX         (hpix),
    .VPIX         (vpix),
    .HBLANK       (hblank),
    .VBLANK       (vblank),
    .SCREEN_FLIP  (flip),
    .cpu          (cpu),
    .HPIXSCRL     (hscrl),
    .VPIXSCRL     (vscrl),
    .scroll_dirty (dirty)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model state
  int m_sx, m_sy, m_ax, m_ay;
  bit m_dirty;
  int last_h, last_v;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_sx = 0; m_sy = 0; m_ax = 0; m_ay = 0; m_dirty = 0;
    last_h = 0; last_v = 0;
  endtask

  task automatic model_write(input int a, input int d);
    case (a)
      0: m_sx = (m_sx & 256) | d;
      1: m_sx = (m_sx & 255) | ((d & 1) * 256);
      2: m_sy = d;
      default: ;
    endcase
    m_dirty = 1;
  endtask

  task automatic pixel(input string tag, input int h, input int v, input bit f);
    @(negedge clk);
    hpix = h[8:0]; vpix = v[7:0]; flip = f; pixel_ce = 1'b1;
    @(negedge clk);
    pixel_ce = 1'b0;
    last_h = ((f ? 511 - h : h) + m_ax) % 512;
    last_v = ((f ? 255 - v : v) + m_ay) % 256;
    check({tag, "_h"}, 16'(hscrl), 16'(last_h));
    check({tag, "_v"}, 16'(vscrl), 16'(last_v));
  endtask

  task automatic hold_check(input string tag);
    @(negedge clk);
    hpix = 9'(~hpix); vpix = 8'(~vpix);
    repeat (3) @(negedge clk);
    check({tag, "_h"}, 16'(hscrl), 16'(last_h));
    check({tag, "_v"}, 16'(vscrl), 16'(last_v));
  endtask

  task automatic cpu_write(input int a, input int d, input int hold);
    @(negedge clk);
    cpu.SCROLL_CS = 1'b0; cpu.Z80_WR = 1'b0;
    cpu.CPU_ADDR = a[1:0]; cpu.CPU_DIN = d[7:0];
    repeat (hold) @(negedge clk);
    cpu.SCROLL_CS = 1'b1; cpu.Z80_WR = 1'b1;
    @(negedge clk);
    model_write(a, d);
  endtask

  task automatic vblank_pulse();
    @(negedge clk); vblank = 1'b1;
    @(negedge clk); vblank = 1'b0;
    m_ax = m_sx; m_ay = m_sy; m_dirty = 0;
  endtask

  task automatic hblank_pulse();
    @(negedge clk); hblank = 1'b1;
    @(negedge clk); hblank = 1'b0;
`ifdef BG_LINE_SCROLL_EN
    m_ax = m_sx;
`endif
  endtask

  initial begin
    cpu.SCROLL_CS = 1'b1; cpu.Z80_WR = 1'b1; cpu.CPU_ADDR = '0; cpu.CPU_DIN = '0;
    model_reset();
    #2;
    check("rst_h", 16'(hscrl), 16'h0);
    check("rst_v", 16'(vscrl), 16'h0);
    check("rst_dirty", 16'(dirty), 16'h0);
    @(negedge clk); rst_n = 1'b1;
    pixel("first", 5, 3, 1'b0);
    check("first_lit_h", 16'(hscrl), 16'h5);

    // Strobe held across reset counts as a fresh write after release
    @(negedge clk);
    cpu.SCROLL_CS = 1'b0; cpu.Z80_WR = 1'b0; cpu.CPU_ADDR = 2'd2; cpu.CPU_DIN = 8'h33;
    @(negedge clk); rst_n = 1'b0;
    #1 check("midstrobe_rst_dirty", 16'(dirty), 16'h0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    cpu.SCROLL_CS = 1'b1; cpu.Z80_WR = 1'b1;
    @(negedge clk);
    model_reset(); model_write(2, 8'h33);
    check("midstrobe_dirty", 16'(dirty), 16'(m_dirty));
    vblank_pulse();
    pixel("midstrobe_y", 0, 0, 1'b0);

    // Example frame: writes stay pending until VBLANK
    cpu_write(0, 8'h10, 2);
    cpu_write(1, 8'h01, 3);
    cpu_write(2, 8'h20, 2);
    check("pend_dirty", 16'(dirty), 16'h1);
    pixel("pend", 9'h0F0, 8'hE8, 1'b0);
    vblank_pulse();
    check("latch_dirty", 16'(dirty), 16'h0);
    pixel("wrap", 9'h0F0, 8'hE8, 1'b0);
    check("wrap_lit_h", 16'(hscrl), 16'h000);
    check("wrap_lit_v", 16'(vscrl), 16'h008);
    hold_check("hold");

    // Long strobe with data changing: single capture of the first value
    @(negedge clk);
    cpu.SCROLL_CS = 1'b0; cpu.Z80_WR = 1'b0; cpu.CPU_ADDR = 2'd0; cpu.CPU_DIN = 8'h11;
    repeat (5) @(negedge clk);
    cpu.CPU_DIN = 8'h22;
    repeat (15) @(negedge clk);
    cpu.SCROLL_CS = 1'b1; cpu.Z80_WR = 1'b1;
    @(negedge clk);
    model_write(0, 8'h11);
    vblank_pulse();
    pixel("long_strobe", 0, 0, 1'b0);
    check("long_strobe_lit", 16'(hscrl), 16'h111);

    // Capture coincident with VBLANK rise
    cpu_write(2, 8'h00, 2);
    vblank_pulse();
    @(negedge clk);
    cpu.SCROLL_CS = 1'b0; cpu.Z80_WR = 1'b0; cpu.CPU_ADDR = 2'd2; cpu.CPU_DIN = 8'h40;
    @(negedge clk); vblank = 1'b1;
    @(negedge clk); cpu.SCROLL_CS = 1'b1; cpu.Z80_WR = 1'b1;
    @(negedge clk); vblank = 1'b0;
    m_ax = m_sx; m_ay = m_sy; m_sy = 8'h40; m_dirty = 1;
    check("coinc_dirty", 16'(dirty), 16'h1);
    pixel("coinc_old", 0, 0, 1'b0);
    check("coinc_lit_v", 16'(vscrl), 16'h00);
    vblank_pulse();
    pixel("coinc_new", 0, 0, 1'b0);
    check("coinc_new_lit_v", 16'(vscrl), 16'h40);

    // Flipped screen
    cpu_write(0, 2, 2);
    cpu_write(1, 0, 2);
    cpu_write(2, 1, 2);
    vblank_pulse();
    pixel("flip", 0, 0, 1'b1);
    check("flip_lit_h", 16'(hscrl), 16'h001);
    check("flip_lit_v", 16'(vscrl), 16'h000);

    // Mid-frame X write then HBLANK rise
    cpu_write(0, 8'h80, 2);
    cpu_write(1, 0, 2);
    hblank_pulse();
    pixel("line", 0, 0, 1'b0);
`ifdef BG_LINE_SCROLL_EN
    check("line_lit_h", 16'(hscrl), 16'h080);
`else
    check("line_lit_h", 16'(hscrl), 16'h002);
`endif
    check("line_dirty", 16'(dirty), 16'h1);
    vblank_pulse();
    pixel("line_vb", 0, 0, 1'b0);

    // Reset mid-frame with non-zero state
    @(negedge clk); rst_n = 1'b0;
    #1;
    check("rst2_h", 16'(hscrl), 16'h0);
    check("rst2_v", 16'(vscrl), 16'h0);
    check("rst2_dirty", 16'(dirty), 16'h0);
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    pixel("rst2_pix", 9'h1AB, 8'h5C, 1'b0);

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 4))
        0, 1: cpu_write(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
                        int'($urandom_range(2, 5)));
        2: vblank_pulse();
        3: hblank_pulse();
        default: pixel("rnd", int'($urandom_range(0, 511)), int'($urandom_range(0, 255)),
                       bit'($urandom_range(0, 1)));
      endcase
      check("rnd_dirty", 16'(dirty), 16'(m_dirty));
    end
    pixel("rnd_final", int'($urandom_range(0, 511)), int'($urandom_range(0, 255)), 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
